// File: rtl/rom_seq_reader_pkg.sv
// Shared types and defaults for the ROM sequential reader.
package rom_seq_reader_pkg;

  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_W = 16;
  localparam int ROM_DEPTH  = 1 << DEF_ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/rom_seq_fifo.sv
// First-word-fall-through output buffer with occupancy count.
module rom_seq_fifo
  import rom_seq_reader_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [OCC_W-1:0]  occ,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Popping an empty buffer is a no-op; the reader never overflows it.
  assign do_pop = pop && (occ != '0);
  assign empty  = (occ == '0);
  // Head reads as zero when empty so a reset clears the visible word at once.
  assign head   = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are meaningless outside the occupied window.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push)   wr_ptr <= next_ptr(wr_ptr);
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      occ <= occ + OCC_W'(push) - OCC_W'(do_pop);
    end
  end

endmodule

// File: rtl/rom_seq_reader.sv
// Burst address sequencer for a 1-cycle-latency synchronous ROM, with a
// small output buffer presenting the words on a valid/ready stream.
module rom_seq_reader
  import rom_seq_reader_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  input  logic              loop,
  input  logic              stop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  state_t            state;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W:0]   cnt_r;
  logic [ADDR_W:0]   remaining;
  logic              loop_r;
  // vld_pipe[0]: address issued last edge; vld_pipe[1]: ROM data valid now.
  logic [1:0]        vld_pipe;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W:0]    used;
  logic              empty;
  logic              pop;
  logic              push;
  logic              issue;
  logic              drain_done;

  assign push = vld_pipe[1];
  assign pop  = out_valid && out_ready;

  // Slots already claimed: buffered words plus words still in the ROM pipe.
  // Same-cycle pops are deliberately not credited.
  assign used = (OCC_W+1)'(occ) + (OCC_W+1)'(vld_pipe[0]) + (OCC_W+1)'(vld_pipe[1]);

  // remaining == 0 while in RUN only happens in loop mode (pass reload).
  assign issue = (state == RUN) && !stop && (used < (OCC_W+1)'(FIFO_DEPTH))
                 && ((remaining != '0) || loop_r);

  // Look ahead so done lands on the very edge the last word leaves.
  assign drain_done = (state == DRAIN) && (vld_pipe == 2'b00)
                      && (empty || ((occ == OCC_W'(1)) && pop));

  // Burst control FSM: address generation, pipe tracking, busy/done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rom_addr  <= '0;
      base_r    <= '0;
      cnt_r     <= '0;
      remaining <= '0;
      loop_r    <= 1'b0;
      vld_pipe  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done     <= 1'b0;
      vld_pipe <= {vld_pipe[0], 1'b0};
      case (state)
        IDLE: begin
          if (start) begin
            busy   <= 1'b1;
            base_r <= base;
            cnt_r  <= count;
            loop_r <= loop;
            if (count != '0) begin
              // First address goes out on the start edge itself.
              rom_addr    <= base;
              vld_pipe[0] <= 1'b1;
              remaining   <= count - (ADDR_W+1)'(1);
              state       <= ((count == (ADDR_W+1)'(1)) && !loop) ? DRAIN : RUN;
            end else begin
              state <= DRAIN;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state <= DRAIN;
          end else if (issue) begin
            vld_pipe[0] <= 1'b1;
            if (remaining == '0) begin
              rom_addr  <= base_r;
              remaining <= cnt_r - (ADDR_W+1)'(1);
            end else begin
              rom_addr  <= rom_addr + ADDR_W'(1);
              remaining <= remaining - (ADDR_W+1)'(1);
              if ((remaining == (ADDR_W+1)'(1)) && !loop_r) state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rom_seq_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W),
    .OCC_W  (OCC_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (rom_data),
    .pop       (pop),
    .head      (out_data),
    .occ       (occ),
    .empty     (empty)
  );

  assign out_valid = !empty;

endmodule

// File: tb/tb_rom_seq_reader.sv
// Bench for rom_seq_reader paired with an 8-word synchronous ROM model.
module tb_rom_seq_reader;

  typedef logic [15:0] wq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  base;
  logic [3:0]  count;
  logic        loop;
  logic        stop;
  logic [2:0]  rom_addr;
  logic [15:0] rom_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  logic [15:0] rom_mem [8] = '{16'habcd, 16'h79ca, 16'h1358, 16'h976a,
                               16'h84ad, 16'hd3f5, 16'hf4a2, 16'hc0d1};

  int checks = 0;
  int failures = 0;

  // Burst observation results
  wq_t         got_q;
  int          first_at, done_at, max_occ;
  bit          stall_bad, busy_bad, timeout, busy_after;
  logic [2:0]  addr0;

  always #5 clk = ~clk;

  // Registered ROM: data appears one edge after the address.
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  rom_seq_reader dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .count(count),
    .loop(loop), .stop(stop), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  function automatic wq_t exp_words(input int b, input int c);
    wq_t q;
    for (int i = 0; i < c; i++) q.push_back(rom_mem[(b + i) % 8]);
    return q;
  endfunction

  function automatic bit same_q(input wq_t a, input wq_t e);
    if (a.size() != e.size()) return 1'b0;
    for (int i = 0; i < a.size(); i++) if (a[i] !== e[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Runs one burst; cycle n means "sampled after edge k+n" where k is the start edge.
  task automatic do_burst(input int b, input int c, input bit lp, input int ready_pct,
                          input int stop_after, input int restart_at);
    bit          stalled, stop_sent;
    logic [15:0] held;
    got_q.delete();
    first_at = -1; done_at = -1; max_occ = 0;
    stall_bad = 0; busy_bad = 0; timeout = 0; busy_after = 1;
    stalled = 0; stop_sent = 0; held = '0;
    @(negedge clk);
    base = 3'(b); count = 4'(c); loop = lp; start = 1'b1; stop = 1'b0;
    @(negedge clk);
    start = 1'b0;
    addr0 = rom_addr;
    for (int n = 0; n < 300; n++) begin
      if (n > 0) @(negedge clk);
      stop  = 1'b0;
      start = 1'b0;
      if (n == restart_at) begin
        start = 1'b1; base = 3'(b + 3); count = 4'd8; loop = 1'b1;
      end
      out_ready = ($urandom_range(99) < ready_pct);
      if (int'(dut.u_fifo.occ) > max_occ) max_occ = int'(dut.u_fifo.occ);
      if (stalled && (!out_valid || out_data !== held)) stall_bad = 1;
      if (done) begin
        done_at = n;
        busy_after = busy;
        break;
      end
      if (!busy) busy_bad = 1;
      if (out_valid && first_at < 0) first_at = n;
      if (out_valid && out_ready) got_q.push_back(out_data);
      stalled = out_valid && !out_ready;
      held = out_data;
      if (stop_after > 0 && got_q.size() == stop_after && !stop_sent) begin
        stop = 1'b1;
        stop_sent = 1;
      end
    end
    if (done_at < 0) timeout = 1;
    out_ready = 1'b0;
    stop = 1'b0;
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; base = '0; count = '0; loop = 1'b0;
    stop = 1'b0; out_ready = 1'b0;
    #1 rst = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rom_addr !== 3'd0 || out_data !== 16'h0) begin
      failures++;
      $display("FAIL reset_state: valid=%b busy=%b done=%b addr=%0d data=%h required 0/0/0/0/0000",
               out_valid, busy, done, rom_addr, out_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    wq_t e;
    do_burst(0, 3, 0, 100, 0, -1);
    e = exp_words(0, 3);
    checks++;
    if (!same_q(got_q, e)) begin
      failures++;
      $display("FAIL basic_words: got %p required %p", got_q, e);
    end
    checks++;
    if (addr0 !== 3'd0) begin
      failures++;
      $display("FAIL basic_addr0: got %0d required 0", addr0);
    end
    checks++;
    if (first_at !== 2) begin
      failures++;
      $display("FAIL basic_latency: first valid at %0d required 2", first_at);
    end
    checks++;
    if (done_at !== 5 || timeout) begin
      failures++;
      $display("FAIL basic_done: done at %0d required 5", done_at);
    end
    checks++;
    if (busy_bad || busy_after !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy: busy_gap=%0b busy_at_done=%0b required 0/0", busy_bad, busy_after);
    end
  endtask

  task automatic test_wrap;
    wq_t e;
    do_burst(6, 4, 0, 100, 0, -1);
    e = exp_words(6, 4);
    checks++;
    if (!same_q(got_q, e)) begin
      failures++;
      $display("FAIL wrap_words: got %p required %p", got_q, e);
    end
    checks++;
    if (addr0 !== 3'd6 || done_at !== 6) begin
      failures++;
      $display("FAIL wrap_timing: addr0=%0d done_at=%0d required 6/6", addr0, done_at);
    end
  endtask

  task automatic test_backpressure;
    wq_t e;
    do_burst(2, 8, 0, 50, 0, -1);
    e = exp_words(2, 8);
    checks++;
    if (!same_q(got_q, e) || timeout) begin
      failures++;
      $display("FAIL bp_words: got %p required %p", got_q, e);
    end
    checks++;
    if (stall_bad) begin
      failures++;
      $display("FAIL bp_stable: out_data changed or dropped while stalled, required stable");
    end
    checks++;
    if (max_occ > 4) begin
      failures++;
      $display("FAIL bp_occupancy: max %0d required <= 4", max_occ);
    end
  endtask

  task automatic test_loop_stop;
    bit ok;
    do_burst(4, 2, 1, 100, 5, -1);
    ok = (got_q.size() >= 5) && (got_q.size() <= 9);
    for (int i = 0; i < got_q.size(); i++)
      if (got_q[i] !== rom_mem[4 + (i % 2)]) ok = 0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL loop_words: got %p required 5..9 words alternating 84ad/d3f5", got_q);
    end
    checks++;
    if (timeout || busy_after !== 1'b0) begin
      failures++;
      $display("FAIL loop_done: timeout=%0b busy_after=%0b required 0/0", timeout, busy_after);
    end
  endtask

  task automatic test_zero_count;
    wq_t e;
    do_burst(3, 0, 0, 100, 0, -1);
    checks++;
    if (got_q.size() != 0 || first_at !== -1) begin
      failures++;
      $display("FAIL zero_words: got %0d words, first valid %0d required none", got_q.size(), first_at);
    end
    checks++;
    if (done_at !== 1) begin
      failures++;
      $display("FAIL zero_done: done at %0d required 1", done_at);
    end
    // Second start while busy must not disturb the running burst.
    do_burst(0, 3, 0, 100, 0, 1);
    e = exp_words(0, 3);
    checks++;
    if (!same_q(got_q, e) || done_at !== 5) begin
      failures++;
      $display("FAIL start_busy: got %p done_at %0d required %p done_at 5", got_q, done_at, e);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL start_busy_idle: busy=%b valid=%b required 0/0", busy, out_valid);
    end
  endtask

  task automatic test_reset_mid;
    wq_t e;
    @(negedge clk);
    base = 3'd0; count = 4'd8; loop = 1'b0; start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || int'(dut.u_fifo.occ) != 2) begin
      failures++;
      $display("FAIL rstmid_pre: valid=%b occ=%0d required 1/2", out_valid, dut.u_fifo.occ);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0 || busy !== 1'b0 || done !== 1'b0 || rom_addr !== 3'd0) begin
      failures++;
      $display("FAIL rstmid_async: valid=%b data=%h busy=%b done=%b addr=%0d required all 0",
               out_valid, out_data, busy, done, rom_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    do_burst(1, 3, 0, 100, 0, -1);
    e = exp_words(1, 3);
    checks++;
    if (!same_q(got_q, e) || first_at !== 2 || done_at !== 5) begin
      failures++;
      $display("FAIL rstmid_after: got %p first %0d done %0d required %p 2 5", got_q, first_at, done_at, e);
    end
  endtask

  task automatic test_random;
    int b, c;
    wq_t e;
    for (int t = 0; t < 6; t++) begin
      b = $urandom_range(7);
      c = $urandom_range(8, 1);
      do_burst(b, c, 0, 60, 0, -1);
      e = exp_words(b, c);
      checks++;
      if (!same_q(got_q, e) || timeout || stall_bad || max_occ > 4) begin
        failures++;
        $display("FAIL random_%0d: base=%0d count=%0d got %p required %p stall=%0b occ=%0d",
                 t, b, c, got_q, e, stall_bad, max_occ);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_loop_stop();
    test_zero_count();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
